// File: rtl/cmsdk_apb_mux_pkg.sv
// cmsdk_apb_mux_pkg: shared FSM states, slot-index width and default-slave response for the APB slave mux.
package cmsdk_apb_mux_pkg;
   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, ABORT} state_t;
   localparam int SLOT_W = 4;
   localparam int DEF_PRDATA = 0;
   localparam logic DEF_ERR = 1'b1;
endpackage

// File: rtl/cmsdk_apb_mux_wdt.sv
// cmsdk_apb_mux_wdt: saturating ACCESS wait counter; expire flags the cycle the count reaches limit.
module cmsdk_apb_mux_wdt #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         inc,
   input  logic [W-1:0] limit,
   output logic         expire
);
   logic [W-1:0] cnt;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt <= '0;
      else if (clr) cnt <= '0;
      else if (inc && cnt != '1) cnt <= cnt + 1'b1;
   assign expire = cnt == limit;
endmodule

// File: rtl/cmsdk_apb_slave_mux_tmo.sv
// cmsdk_apb_slave_mux_tmo: APB3 slave mux with slot decode, default error slave and optional
// per-transfer timeout (enabled by defining CMSDK_APB_MUX_TIMEOUT_EN).
module cmsdk_apb_slave_mux_tmo
   import cmsdk_apb_mux_pkg::*;
#(
   parameter int          NUM_SLAVES     = 6,
   parameter logic [15:0] PORT_EN        = 16'h003F,
   parameter int          ADDRWIDTH      = 16,
   parameter int          DEC_LSB        = 12,
   parameter int          DATAW          = 32,
   parameter int          TIMEOUT_CYCLES = 256
) (
   input  logic                        PCLK,
   input  logic                        PRESETn,
   input  logic                        PSEL,
   input  logic                        PENABLE,
   input  logic [ADDRWIDTH-1:0]        PADDR,
   output logic [NUM_SLAVES-1:0]       PSELS,
   input  logic [NUM_SLAVES-1:0]       PREADYS,
   input  logic [NUM_SLAVES*DATAW-1:0] PRDATAS,
   input  logic [NUM_SLAVES-1:0]       PSLVERRS,
   output logic                        PREADY,
   output logic [DATAW-1:0]            PRDATA,
   output logic                        PSLVERR,
   output logic                        TMO_EVT
);
   state_t st_q, phase, cur, nxt;
   logic [SLOT_W-1:0] dec, sel_q;
   logic hit, hit_q, expire, rdy_sel, err_sel, acc_hit;
   logic [15:0] rdy_all, err_all;
   logic [DATAW-1:0] rdata [16];
   assign dec = PADDR[DEC_LSB +: SLOT_W];
   assign hit = ({1'b0, dec} < 5'(NUM_SLAVES)) && PORT_EN[dec];
   assign rdy_all = 16'(PREADYS);
   assign err_all = 16'(PSLVERRS);
   assign rdy_sel = rdy_all[sel_q];
   assign err_sel = err_all[sel_q];
   for (genvar g = 0; g < 16; g++) begin : g_rd
      if (g < NUM_SLAVES) begin : g_on
         assign rdata[g] = PRDATAS[g*DATAW +: DATAW];
      end else begin : g_off
         assign rdata[g] = '0;
      end
   end
   // Bus phase tracks the bridge directly so mapped slaves see no added latency; only ABORT is sticky.
   always_comb begin
      phase = !PSEL ? IDLE : !PENABLE ? SETUP : ACCESS;
      cur   = (st_q == ABORT && PSEL) ? ABORT : phase;
      nxt   = (cur == ACCESS && hit_q && !rdy_sel && expire) ? ABORT : cur == ABORT ? IDLE : cur;
   end
   always_ff @(posedge PCLK or negedge PRESETn)
      if (!PRESETn) begin
         st_q  <= IDLE;
         sel_q <= '0;
         hit_q <= 1'b0;
      end else begin
         st_q <= nxt;
         if (cur == SETUP) begin
            sel_q <= dec;
            hit_q <= hit;
         end
      end
   for (genvar s = 0; s < NUM_SLAVES; s++) begin : g_sel
      assign PSELS[s] = PSEL && (cur == SETUP ? (dec == SLOT_W'(s) && hit)
                                              : (cur == ACCESS && sel_q == SLOT_W'(s) && hit_q));
   end
   assign acc_hit = cur == ACCESS && hit_q;
   assign PREADY  = acc_hit ? rdy_sel : 1'b1;
   assign PRDATA  = acc_hit ? rdata[sel_q] : DATAW'(DEF_PRDATA);
   assign PSLVERR = acc_hit ? err_sel && rdy_sel : (cur == ACCESS || cur == ABORT) ? DEF_ERR : 1'b0;
`ifdef CMSDK_APB_MUX_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES);
   logic tmo_q;
   cmsdk_apb_mux_wdt #(.W(TW)) u_wdt (
      .clk    (PCLK),
      .rst_n  (PRESETn),
      .clr    (cur != ACCESS),
      .inc    (acc_hit && !rdy_sel),
      .limit  (TW'(TIMEOUT_CYCLES - 1)),
      .expire (expire)
   );
   always_ff @(posedge PCLK or negedge PRESETn)
      if (!PRESETn) tmo_q <= 1'b0;
      else tmo_q <= nxt == ABORT;
   assign TMO_EVT = tmo_q;
`else
   assign expire  = 1'b0;
   assign TMO_EVT = 1'b0;
`endif
endmodule

// File: tb/tb_cmsdk_apb_slave_mux_tmo.sv
// tb_cmsdk_apb_slave_mux_tmo: directed bench for the APB slave mux; timeout cases run when
// CMSDK_APB_MUX_TIMEOUT_EN is defined, the hung-slave case otherwise.
module tb_cmsdk_apb_slave_mux_tmo;
   logic        pclk = 1'b0;
   logic        presetn = 1'b0;
   logic        psel = 1'b0, penable = 1'b0;
   logic [15:0] paddr = '0;
   logic [5:0]  preadys = '1, pslverrs = '0;
   logic [191:0] prdatas;
   logic [5:0]  psels, psels_b;
   logic        pready, pslverr, tmo_evt, pready_b, pslverr_b, tmo_evt_b;
   logic [31:0] prdata, prdata_b;
   int n_chk = 0, n_err = 0;

   always #5 pclk = ~pclk;

   for (genvar i = 0; i < 6; i++) begin : g_data
      assign prdatas[i*32 +: 32] = 32'hCAFE0000 | i;
   end

   cmsdk_apb_slave_mux_tmo #(.TIMEOUT_CYCLES(4)) u_dut (
      .PCLK(pclk), .PRESETn(presetn), .PSEL(psel), .PENABLE(penable), .PADDR(paddr),
      .PSELS(psels), .PREADYS(preadys), .PRDATAS(prdatas), .PSLVERRS(pslverrs),
      .PREADY(pready), .PRDATA(prdata), .PSLVERR(pslverr), .TMO_EVT(tmo_evt));

   cmsdk_apb_slave_mux_tmo #(.PORT_EN(16'h003B), .TIMEOUT_CYCLES(4)) u_dut_b (
      .PCLK(pclk), .PRESETn(presetn), .PSEL(psel), .PENABLE(penable), .PADDR(paddr),
      .PSELS(psels_b), .PREADYS(preadys), .PRDATAS(prdatas), .PSLVERRS(pslverrs),
      .PREADY(pready_b), .PRDATA(prdata_b), .PSLVERR(pslverr_b), .TMO_EVT(tmo_evt_b));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge pclk);
      #1;
   endtask

   initial begin
      int hi;
      #2;
      chk("rst_psels", 32'(psels), 0);
      chk("rst_pready", 32'(pready), 1);
      chk("rst_pslverr", 32'(pslverr), 0);
      chk("rst_prdata", prdata, 0);
      chk("rst_tmo", 32'(tmo_evt), 0);
      cyc(); presetn = 1'b1;
      // mapped slot 3, two wait states
      cyc(); psel = 1; penable = 0; paddr = 16'h3004; preadys = 6'b110111; #2;
      chk("t1_setup_psels", 32'(psels), 32'b001000);
      cyc(); penable = 1; #2;
      chk("t1_acc1_psels", 32'(psels), 32'b001000);
      chk("t1_acc1_pready", 32'(pready), 0);
      cyc(); #2;
      chk("t1_acc2_pready", 32'(pready), 0);
      cyc(); preadys = '1; #2;
      chk("t1_acc3_pready", 32'(pready), 1);
      chk("t1_acc3_prdata", prdata, 32'hCAFE0003);
      chk("t1_acc3_pslverr", 32'(pslverr), 0);
      chk("t1_acc3_psels", 32'(psels), 32'b001000);
      cyc(); psel = 0; penable = 0; #2;
      chk("t1_idle_psels", 32'(psels), 0);
      // unmapped: slot index beyond NUM_SLAVES
      cyc(); psel = 1; paddr = 16'h9000; #2;
      chk("t2_setup_psels", 32'(psels), 0);
      cyc(); penable = 1; #2;
      chk("t2_acc_psels", 32'(psels), 0);
      chk("t2_acc_pready", 32'(pready), 1);
      chk("t2_acc_pslverr", 32'(pslverr), 1);
      chk("t2_acc_prdata", prdata, 0);
      cyc(); psel = 0; penable = 0;
      // slot 2: mapped in u_dut, disabled by PORT_EN in u_dut_b
      cyc(); psel = 1; paddr = 16'h2000; #2;
      chk("t2b_setup_psels_b", 32'(psels_b), 0);
      chk("t2b_setup_psels", 32'(psels), 32'b000100);
      cyc(); penable = 1; #2;
      chk("t2b_acc_psels_b", 32'(psels_b), 0);
      chk("t2b_acc_pready_b", 32'(pready_b), 1);
      chk("t2b_acc_pslverr_b", 32'(pslverr_b), 1);
      chk("t2b_acc_prdata_b", prdata_b, 0);
      chk("t2b_acc_prdata", prdata, 32'hCAFE0002);
      chk("t2b_acc_pslverr", 32'(pslverr), 0);
      cyc(); psel = 0; penable = 0;
      // back-to-back slot 0 then slot 4 (slot 4 errors after one wait state)
      cyc(); psel = 1; paddr = 16'h0000; #2;
      chk("t6_setup0_psels", 32'(psels), 32'b000001);
      cyc(); penable = 1; #2;
      chk("t6_acc0_psels", 32'(psels), 32'b000001);
      chk("t6_acc0_prdata", prdata, 32'hCAFE0000);
      chk("t6_acc0_pready", 32'(pready), 1);
      cyc(); penable = 0; paddr = 16'h4000; preadys = 6'b101111; pslverrs = 6'b010000; #2;
      chk("t6_setup4_psels", 32'(psels), 32'b010000);
      cyc(); penable = 1; #2;
      chk("t6_acc4_psels", 32'(psels), 32'b010000);
      chk("t6_acc4_pready_w", 32'(pready), 0);
      chk("t6_acc4_pslverr_w", 32'(pslverr), 0);
      cyc(); preadys = '1; #2;
      chk("t6_acc4_pready", 32'(pready), 1);
      chk("t6_acc4_prdata", prdata, 32'hCAFE0004);
      chk("t6_acc4_pslverr", 32'(pslverr), 1);
      cyc(); psel = 0; penable = 0; pslverrs = '0;
      // reset during a slot 5 wait
      cyc(); psel = 1; paddr = 16'h5000; preadys = 6'b011111; #2;
      cyc(); penable = 1; #2;
      chk("t5_acc_psels", 32'(psels), 32'b100000);
      chk("t5_acc_pready", 32'(pready), 0);
      cyc(); presetn = 0; psel = 0; penable = 0; #2;
      chk("t5_rst_psels", 32'(psels), 0);
      chk("t5_rst_tmo", 32'(tmo_evt), 0);
      chk("t5_rst_pready", 32'(pready), 1);
      chk("t5_rst_pslverr", 32'(pslverr), 0);
      cyc(); presetn = 1; preadys = '1;
      cyc(); psel = 1; paddr = 16'h0010; #2;
      chk("t5_setup0_psels", 32'(psels), 32'b000001);
      cyc(); penable = 1; #2;
      chk("t5_acc0_pready", 32'(pready), 1);
      chk("t5_acc0_prdata", prdata, 32'hCAFE0000);
      chk("t5_acc0_pslverr", 32'(pslverr), 0);
      cyc(); psel = 0; penable = 0;
`ifdef CMSDK_APB_MUX_TIMEOUT_EN
      // slot 1 hangs: four waits then a one-cycle abort
      cyc(); psel = 1; paddr = 16'h1000; preadys = 6'b111101;
      for (int k = 0; k < 4; k++) begin
         cyc(); penable = 1; #2;
         chk($sformatf("t3_wait%0d_pready", k), 32'(pready), 0);
         chk($sformatf("t3_wait%0d_tmo", k), 32'(tmo_evt), 0);
      end
      cyc(); #2;
      chk("t3_abort_pready", 32'(pready), 1);
      chk("t3_abort_pslverr", 32'(pslverr), 1);
      chk("t3_abort_tmo", 32'(tmo_evt), 1);
      chk("t3_abort_psels", 32'(psels), 0);
      chk("t3_abort_prdata", prdata, 0);
      cyc(); psel = 0; penable = 0; #2;
      chk("t3_idle_tmo", 32'(tmo_evt), 0);
      chk("t3_idle_pslverr", 32'(pslverr), 0);
      // slot 1 answers on the limit cycle: slave wins
      cyc(); psel = 1; paddr = 16'h1000;
      for (int k = 0; k < 3; k++) begin
         cyc(); penable = 1; #2;
         chk($sformatf("t4_wait%0d_pready", k), 32'(pready), 0);
      end
      cyc(); preadys = '1; pslverrs = 6'b000010; #2;
      chk("t4_done_pready", 32'(pready), 1);
      chk("t4_done_pslverr", 32'(pslverr), 1);
      chk("t4_done_prdata", prdata, 32'hCAFE0001);
      chk("t4_done_tmo", 32'(tmo_evt), 0);
      cyc(); psel = 0; penable = 0; pslverrs = '0; #2;
      chk("t4_after_tmo", 32'(tmo_evt), 0);
`else
      // without timeout a hung slave stalls indefinitely
      cyc(); psel = 1; paddr = 16'h1000; preadys = 6'b111101;
      cyc(); penable = 1;
      hi = 0;
      for (int k = 0; k < 1000; k++) begin
         #2;
         if (pready !== 1'b0 || tmo_evt !== 1'b0) hi++;
         cyc();
      end
      #2;
      chk("t6_hang_ready_cycles", 32'(hi), 0);
      chk("t6_hang_psels", 32'(psels), 32'b000010);
      preadys = '1; #1;
      chk("t6_hang_release_pready", 32'(pready), 1);
      chk("t6_hang_release_prdata", prdata, 32'hCAFE0001);
      cyc(); psel = 0; penable = 0;
`endif
      cyc();
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
